lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised LFSR pseudo-random source, successor to the fixed 4-bit seeded LFSR. Supports any width 3–32, an arbitrary tap mask, and both Fibonacci and Galois forms. Each value is delivered over a valid/ready stream with enable/pause control. Hardware detects period wrap and reports the measured sequence length, for use as a test-pattern and scrambler source in the datapath benches.

## Interface
- WIDTH, 8: state/output width, 3..32.
- TAPS, 8'hB8: feedback polynomial mask, WIDTH bits; bit i set = tap on state bit i.
- MODE, 0: 0 = Fibonacci (shift left, XOR feedback into bit 0); 1 = Galois (shift right, conditional XOR of TAPS).
- DEFAULT_SEED, all ones: reset/substitute seed; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value sampled when load=1.
- en  in  1  run enable; 0 pauses generation.
- out_ready  in  1  consumer accepts out this cycle.
- out_valid  out  1  out holds a valid sample.
- out  out  WIDTH  current LFSR state.
- seed_err  out  1  one-cycle pulse: zero seed was loaded and replaced.
- wrap  out  1  one-cycle pulse: sequence returned to its start value.
- period  out  WIDTH  length of the last completed sequence, in accepted transfers.

## Operation
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE.
- IDLE -> RUN on load=1 or en=1. RUN -> PAUSE when en=0 and load=0. PAUSE -> RUN when en=1 or load=1.
- out_valid is registered: 1 only in RUN.
- A transfer happens when out_valid=1, out_ready=1 and load=0. On a transfer: state <= next(state), count <= count+1.
- Fibonacci next state: {state[WIDTH-2:0], ^(state & TAPS)}.
- Galois next state: (state >> 1) ^ (state[0] ? TAPS : 0).
- Load has priority over transfer. On load: state <= seed, start <= seed, count <= 0. A simultaneous out_ready is ignored and the transfer is not counted.
- Zero seed: state and start <= DEFAULT_SEED, and seed_err pulses the next cycle.
- Wrap: on a transfer where next(state)==start:
  - wrap pulses the next cycle;
  - period <= count+1;
  - count <= 0.
- count and period are WIDTH bits. A maximal polynomial gives 2^WIDTH-1, which fits. A non-maximal mask still wraps at its own cycle length.
- en=0 while out_valid=1 and out_ready=1 in the same cycle: the transfer completes, then the FSM enters PAUSE.

## Timing
- Reset values:
  - state = start = DEFAULT_SEED;
  - out = DEFAULT_SEED;
  - out_valid = 0;
  - seed_err = 0;
  - wrap = 0;
  - period = 0;
  - count = 0.
- Reset assertion mid-run clears everything immediately (asynchronous). Release is synchronous to the next clk edge.
- Latency:
  - load at edge N: out = seed and out_valid = 1 after edge N (value visible in cycle N+1).
  - Transfer at edge N: the new out is visible in cycle N+1, so one sample per cycle is possible at full rate.
- out is stable while out_valid=1 and out_ready=0 (backpressure holds state).
- seed_err and wrap are registered single-cycle pulses. They never stretch.

## Structure
- Package lfsr_pkg holds:
  - the FSM state enum (IDLE/RUN/PAUSE);
  - MODE constants (MODE_FIB, MODE_GAL);
  - maximal tap constants per width (e.g. TAPS_4 = 4'b1100, TAPS_8 = 8'hB8, TAPS_16 = 16'hB400).
- One combinational sub-module, lfsr_step: inputs state, outputs next state, parametrised on WIDTH/TAPS/MODE. Used for both the advance and the wrap compare.
- Top lfsr_gen contains the FSM, the state/start/count/period registers and the pulse outputs.

## Test plan
- Reset with WIDTH=4, TAPS=4'b1100, MODE=0 -> out=1111, out_valid=0, period=0; all pulses low.
- load=1, seed=1111, en=1, out_ready=1 held -> out sequence 1111,1110,1100,1000,0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111. wrap pulses once, after the 15th transfer; period=15.
- MODE=1, seed=0001, out_ready=1 -> 0001,1100,0110,0011,1101. Full run gives period=15.
- load seed=0000 -> out=1111 (DEFAULT_SEED); seed_err high for exactly one cycle.
- Toggle out_ready 1/0 with en=1 -> out holds while out_ready=0 and no values are skipped. Drop en -> out_valid=0 from the next cycle; raise en -> resumes from the same value.
- Assert load together with out_ready mid-sequence, then pull reset low mid-run -> seed loaded with no extra advance and count=0. Reset returns all outputs to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised LFSR generator.
// Maximal tap masks are given in the Fibonacci (shift-left) orientation.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } lfsr_state_e;

    localparam int unsigned MODE_FIB = 0;
    localparam int unsigned MODE_GAL = 1;

    localparam logic [2:0]  TAPS_3  = 3'b110;
    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [4:0]  TAPS_5  = 5'b10100;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_step.sv
// One LFSR advance: maps the current state to its successor.
// Fibonacci and Galois forms are selected at elaboration time by MODE.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
    parameter int unsigned       MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    generate
        if (MODE == MODE_GAL) begin : g_galois
            always_comb begin
                next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
            end
        end else begin : g_fibonacci
            always_comb begin
                next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
            end
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pseudo-random source on a valid/ready stream with run/pause control,
// zero-seed substitution, and hardware measurement of the sequence period.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0]  TAPS         = 8'hB8,
    parameter int unsigned       MODE         = MODE_FIB,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             seed_err,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             seed_err_q, seed_err_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_eff;
    logic             seed_zero;
    logic             xfer;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_step (
        .state_i (lfsr_q),
        .next_o  (lfsr_next)
    );

    assign seed_zero = (seed == '0);
    assign seed_eff  = seed_zero ? DEFAULT_SEED : seed;
    // Load wins over a simultaneous handshake, so such a cycle is not a transfer.
    assign xfer      = (fsm_q == RUN) && out_ready && !load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (load || en)   fsm_d = RUN;
            RUN:     if (!en && !load) fsm_d = PAUSE;
            PAUSE:   if (load || en)   fsm_d = RUN;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (fsm_q == RUN);
        out       = lfsr_q;
        seed_err  = seed_err_q;
        wrap      = wrap_q;
        period    = period_q;
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        start_d    = start_q;
        count_d    = count_q;
        period_d   = period_q;
        seed_err_d = 1'b0;
        wrap_d     = 1'b0;
        if (load) begin
            lfsr_d     = seed_eff;
            start_d    = seed_eff;
            count_d    = '0;
            seed_err_d = seed_zero;
        end else if (xfer) begin
            lfsr_d = lfsr_next;
            if (lfsr_next == start_q) begin
                wrap_d   = 1'b1;
                period_d = count_q + WIDTH'(1);
                count_d  = '0;
            end else begin
                count_d  = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q     <= DEFAULT_SEED;
            start_q    <= DEFAULT_SEED;
            count_q    <= '0;
            period_q   <= '0;
            seed_err_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            start_q    <= start_d;
            count_q    <= count_d;
            period_q   <= period_d;
            seed_err_q <= seed_err_d;
            wrap_q     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a 4-bit Fibonacci and a 4-bit Galois instance share stimulus
// and are compared against a transaction-level reference model.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    localparam logic [3:0] T   = 4'b1100;
    localparam logic [3:0] DEF = 4'hF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed = 4'h0;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;

    logic       f_valid, f_serr, f_wrap;
    logic [3:0] f_out, f_period;
    logic       g_valid, g_serr, g_wrap;
    logic [3:0] g_out, g_period;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = Fibonacci instance, 1 = Galois instance.
    logic [3:0] m_state  [2];
    logic [3:0] m_start  [2];
    logic [3:0] m_period [2];
    int         m_cnt    [2];
    logic       m_wrap   [2];
    logic       m_valid;
    logic       m_serr;

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH        (4),
        .TAPS         (TAPS_4),
        .MODE         (MODE_FIB),
        .DEFAULT_SEED (DEF)
    ) dut_fib (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .en        (en),
        .out_ready (out_ready),
        .out_valid (f_valid),
        .out       (f_out),
        .seed_err  (f_serr),
        .wrap      (f_wrap),
        .period    (f_period)
    );

    lfsr_gen #(
        .WIDTH        (4),
        .TAPS         (TAPS_4),
        .MODE         (MODE_GAL),
        .DEFAULT_SEED (DEF)
    ) dut_gal (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .en        (en),
        .out_ready (out_ready),
        .out_valid (g_valid),
        .out       (g_out),
        .seed_err  (g_serr),
        .wrap      (g_wrap),
        .period    (g_period)
    );

    function automatic logic [3:0] succ(input int k, input logic [3:0] v);
        logic [3:0] r;
        if (k == 0) begin
            r = (v << 1) | 4'(($countones(v & T)) % 2);
        end else begin
            r = v[0] ? ((v >> 1) ^ T) : (v >> 1);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k]  = DEF;
            m_start[k]  = DEF;
            m_period[k] = 4'h0;
            m_cnt[k]    = 0;
            m_wrap[k]   = 1'b0;
        end
        m_valid = 1'b0;
        m_serr  = 1'b0;
    endtask

    // Advance model by one clock using the inputs currently applied, then clock the DUTs.
    task automatic step();
        logic       xfer;
        logic [3:0] n;
        xfer = m_valid && out_ready && !load;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (load) begin
                m_state[k] = (seed == 4'h0) ? DEF : seed;
                m_start[k] = m_state[k];
                m_cnt[k]   = 0;
            end else if (xfer) begin
                n = succ(k, m_state[k]);
                if (n == m_start[k]) begin
                    m_wrap[k]   = 1'b1;
                    m_period[k] = 4'(m_cnt[k] + 1);
                    m_cnt[k]    = 0;
                end else begin
                    m_cnt[k]++;
                end
                m_state[k] = n;
            end
        end
        m_serr  = load && (seed == 4'h0);
        m_valid = en || load;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (f_out !== DEF) begin n_fail++; $display("FAIL reset_out: got %h expected %h", f_out, DEF); end
        n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", f_valid); end
        n_checks++; if (f_period !== 4'h0) begin n_fail++; $display("FAIL reset_period: got %h expected 0", f_period); end
        n_checks++; if ({f_serr, f_wrap, g_serr, g_wrap} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {f_serr, f_wrap, g_serr, g_wrap}); end
        n_checks++; if (g_out !== DEF) begin n_fail++; $display("FAIL reset_gal_out: got %h expected %h", g_out, DEF); end
        reset = 1'b1;
    endtask

    task automatic test_fib_sequence();
        logic [3:0] exp_seq [16];
        exp_seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                    4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
        load = 1'b1; seed = 4'hF; en = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        n_checks++; if (f_out !== exp_seq[0] || f_valid !== 1'b1) begin n_fail++; $display("FAIL fib_load: got %h/%b expected %h/1", f_out, f_valid, exp_seq[0]); end
        for (int i = 1; i < 16; i++) begin
            step();
            n_checks++; if (f_out !== exp_seq[i]) begin n_fail++; $display("FAIL fib_seq[%0d]: got %h expected %h", i, f_out, exp_seq[i]); end
            n_checks++; if (f_wrap !== (i == 15)) begin n_fail++; $display("FAIL fib_wrap[%0d]: got %b expected %b", i, f_wrap, (i == 15)); end
            n_checks++; if (g_out !== m_state[1]) begin n_fail++; $display("FAIL gal_par[%0d]: got %h expected %h", i, g_out, m_state[1]); end
        end
        n_checks++; if (f_period !== 4'd15) begin n_fail++; $display("FAIL fib_period: got %0d expected 15", f_period); end
        step();
        n_checks++; if (f_wrap !== 1'b0) begin n_fail++; $display("FAIL fib_wrap_width: got %b expected 0", f_wrap); end
    endtask

    task automatic test_galois();
        logic [3:0] exp_seq [5];
        bit seen;
        exp_seq = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD};
        load = 1'b1; seed = 4'h1; en = 1'b1; out_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (g_out !== exp_seq[i]) begin n_fail++; $display("FAIL gal_seq[%0d]: got %h expected %h", i, g_out, exp_seq[i]); end
            step();
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (g_wrap === 1'b1) seen = 1;
            else step();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL gal_wrap_timeout: got no wrap expected wrap within 20 cycles"); end
        n_checks++; if (g_period !== 4'd15) begin n_fail++; $display("FAIL gal_period: got %0d expected 15", g_period); end
        n_checks++; if (f_period !== m_period[0]) begin n_fail++; $display("FAIL fib_period_model: got %0d expected %0d", f_period, m_period[0]); end
    endtask

    task automatic test_zero_seed();
        out_ready = 1'b0; load = 1'b1; seed = 4'h0;
        step();
        load = 1'b0;
        n_checks++; if (f_out !== DEF || g_out !== DEF) begin n_fail++; $display("FAIL zero_seed_out: got %h/%h expected %h", f_out, g_out, DEF); end
        n_checks++; if (f_serr !== 1'b1 || g_serr !== 1'b1) begin n_fail++; $display("FAIL zero_seed_err: got %b/%b expected 1", f_serr, g_serr); end
        step();
        n_checks++; if (f_serr !== 1'b0 || g_serr !== 1'b0) begin n_fail++; $display("FAIL zero_seed_pulse: got %b/%b expected 0", f_serr, g_serr); end
    endtask

    task automatic test_backpressure();
        logic [3:0] held;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            n_checks++; if (f_out !== m_state[0] || g_out !== m_state[1]) begin n_fail++; $display("FAIL bp_out[%0d]: got %h/%h expected %h/%h", i, f_out, g_out, m_state[0], m_state[1]); end
            n_checks++; if (f_wrap !== m_wrap[0] || g_wrap !== m_wrap[1]) begin n_fail++; $display("FAIL bp_wrap[%0d]: got %b/%b expected %b/%b", i, f_wrap, g_wrap, m_wrap[0], m_wrap[1]); end
        end
        en = 1'b0; out_ready = 1'b1;
        step();
        held = m_state[0];
        n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid: got %b expected 0", f_valid); end
        repeat (3) step();
        n_checks++; if (f_out !== held) begin n_fail++; $display("FAIL pause_hold: got %h expected %h", f_out, held); end
        en = 1'b1; out_ready = 1'b0;
        step();
        n_checks++; if (f_valid !== 1'b1 || f_out !== held) begin n_fail++; $display("FAIL resume: got %b/%h expected 1/%h", f_valid, f_out, held); end
    endtask

    task automatic test_load_with_ready();
        bit seen;
        en = 1'b1; out_ready = 1'b1;
        repeat (5) step();
        load = 1'b1; seed = 4'hA;
        step();
        load = 1'b0;
        n_checks++; if (f_out !== 4'hA || g_out !== 4'hA) begin n_fail++; $display("FAIL load_ready_out: got %h/%h expected a", f_out, g_out); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (f_wrap === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL load_ready_wrap_timeout: got no wrap expected wrap within 20 cycles"); end
        n_checks++; if (f_period !== 4'd15) begin n_fail++; $display("FAIL load_ready_period: got %0d expected 15", f_period); end
        n_checks++; if (g_period !== m_period[1]) begin n_fail++; $display("FAIL load_ready_gal_period: got %0d expected %0d", g_period, m_period[1]); end
    endtask

    task automatic test_async_reset();
        en = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (f_out !== DEF || g_out !== DEF) begin n_fail++; $display("FAIL async_out: got %h/%h expected %h", f_out, g_out, DEF); end
        n_checks++; if (f_valid !== 1'b0 || g_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b/%b expected 0", f_valid, g_valid); end
        n_checks++; if (f_period !== 4'h0 || g_period !== 4'h0) begin n_fail++; $display("FAIL async_period: got %h/%h expected 0", f_period, g_period); end
        n_checks++; if ({f_serr, f_wrap, g_serr, g_wrap} !== 4'b0000) begin n_fail++; $display("FAIL async_pulses: got %b expected 0000", {f_serr, f_wrap, g_serr, g_wrap}); end
        @(posedge clk);
        #1;
        reset = 1'b1; en = 1'b0; out_ready = 1'b0; load = 1'b0;
        step();
        n_checks++; if (f_valid !== 1'b0 || f_out !== DEF) begin n_fail++; $display("FAIL post_reset_idle: got %b/%h expected 0/%h", f_valid, f_out, DEF); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load      = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            en        = ($urandom_range(0, 7) != 0);
            out_ready = 1'($urandom_range(0, 1));
            step();
            n_checks++; if (f_out !== m_state[0] || g_out !== m_state[1]) begin n_fail++; $display("FAIL rnd_out[%0d]: got %h/%h expected %h/%h", i, f_out, g_out, m_state[0], m_state[1]); end
            n_checks++; if (f_valid !== m_valid || g_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b/%b expected %b", i, f_valid, g_valid, m_valid); end
            n_checks++; if (f_serr !== m_serr || g_serr !== m_serr) begin n_fail++; $display("FAIL rnd_serr[%0d]: got %b/%b expected %b", i, f_serr, g_serr, m_serr); end
            n_checks++; if (f_wrap !== m_wrap[0] || g_wrap !== m_wrap[1]) begin n_fail++; $display("FAIL rnd_wrap[%0d]: got %b/%b expected %b/%b", i, f_wrap, g_wrap, m_wrap[0], m_wrap[1]); end
            n_checks++; if (f_period !== m_period[0] || g_period !== m_period[1]) begin n_fail++; $display("FAIL rnd_period[%0d]: got %h/%h expected %h/%h", i, f_period, g_period, m_period[0], m_period[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_fib_sequence();
        test_galois();
        test_zero_seed();
        test_backpressure();
        test_load_with_ready();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
